// File: rtl/spi_shift_engine_pkg.sv
// Shared definitions for the SPI shift engine: FSM state encodings and bit-order constants.
package spi_shift_engine_pkg;

  typedef enum logic [1:0] {
    SE_IDLE  = 2'b00,
    SE_SHIFT = 2'b01,
    SE_DONE  = 2'b10
  } se_state_t;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_shift_engine_bitcounter.sv
// Saturating bit counter for the shift engine; terminal is a registered flag set once count reaches MAX.
module bitcounter #(
  parameter int MAX = 8,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          terminal
);

  localparam logic [CW-1:0] MAX_COUNT = CW'(MAX);

  logic [CW-1:0] r_count;
  logic          r_terminal;
  logic [CW-1:0] w_count_inc;

  assign w_count_inc = r_count + 1'b1;

  // Saturates at MAX so the count can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count    <= '0;
      r_terminal <= 1'b0;
    end else if (inc && (r_count != MAX_COUNT)) begin
      r_count    <= w_count_inc;
      r_terminal <= (w_count_inc == MAX_COUNT);
    end
  end

  assign count    = r_count;
  assign terminal = r_terminal;

endmodule

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI shift engine: loads a word, shifts it out on drive strobes and captures serialIn on sample strobes.
module spi_shift_engine
  import spi_shift_engine_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serialClkposedge,
  input  logic             serialClknegedge,
  input  logic             start,
  input  logic             lsbFirst,
  input  logic             abort,
  input  logic [WIDTH-1:0] parallelIn,
  input  logic             serialIn,
  output logic             serialOut,
  output logic [WIDTH-1:0] parallelOut,
  output logic             busy,
  output logic             done
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  se_state_t        r_state, w_state_next;
  logic [WIDTH-1:0] r_memory, w_memory_next;
  logic             r_serial_out, w_serial_out_next;
  logic             r_order, w_order_next;
  logic             w_clear, w_inc, w_terminal;
  logic [CW-1:0]    w_count;

  bitcounter #(
    .MAX (WIDTH),
    .CW  (CW)
  ) u_bitcounter (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_clear),
    .inc      (w_inc),
    .count    (w_count),
    .terminal (w_terminal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= SE_IDLE;
      r_memory     <= '0;
      r_serial_out <= 1'b0;
      r_order      <= MSB_FIRST;
    end else begin
      r_state      <= w_state_next;
      r_memory     <= w_memory_next;
      r_serial_out <= w_serial_out_next;
      r_order      <= w_order_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_memory_next     = r_memory;
    w_serial_out_next = r_serial_out;
    w_order_next      = r_order;
    w_clear           = 1'b0;
    w_inc             = 1'b0;
    case (r_state)
      SE_IDLE, SE_DONE: begin
        if (start) begin
          w_memory_next     = parallelIn;
          w_order_next      = lsbFirst;
          w_serial_out_next = (lsbFirst == LSB_FIRST) ? parallelIn[0] : parallelIn[WIDTH-1];
          w_clear           = 1'b1;
          w_state_next      = SE_SHIFT;
        end else if (r_state == SE_DONE) begin
          w_state_next = SE_IDLE;
        end
      end
      SE_SHIFT: begin
        // Abort wins over a coincident sample; the drive strobe is only honoured on its own.
        if (abort) begin
          w_state_next = SE_IDLE;
        end else if (serialClkposedge) begin
          w_memory_next = (r_order == LSB_FIRST) ? {serialIn, r_memory[WIDTH-1:1]}
                                                 : {r_memory[WIDTH-2:0], serialIn};
          w_inc         = !w_terminal;
          if (w_count == LAST_BIT) begin
            w_state_next = SE_DONE;
          end
        end else if (serialClknegedge) begin
          w_serial_out_next = (r_order == LSB_FIRST) ? r_memory[0] : r_memory[WIDTH-1];
        end
      end
      default: w_state_next = SE_IDLE;
    endcase
  end

  assign serialOut   = r_serial_out;
  assign parallelOut = r_memory;
  assign busy        = (r_state == SE_SHIFT);
  assign done        = (r_state == SE_DONE);

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Parametrised full-duplex shift engine for the SPI peripheral datapath. Loads a WIDTH-bit word, shifts it out MSB-first or LSB-first on externally supplied serial-clock edge strobes, and simultaneously captures serialIn into the same register. It counts bits itself and raises a one-cycle done pulse when the word is complete. It sits between the SPI edge detector, which produces the strobes, and the multiplier register file, which consumes parallelOut on done.

## Interface
- WIDTH, 8, word length in bits; legal range 2 to 64.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- serialClkposedge  in  1  sample strobe: one-cycle pulse meaning "shift serialIn in now".
- serialClknegedge  in  1  drive strobe: one-cycle pulse meaning "present next bit on serialOut now".
- start  in  1  request to load parallelIn and begin a transfer.
- lsbFirst  in  1  bit order; 0 = MSB first, 1 = LSB first. Latched at start.
- abort  in  1  cancels the current transfer.
- parallelIn  in  WIDTH  word to transmit.
- serialIn  in  1  received serial bit.
- serialOut  out  1  registered transmit bit.
- parallelOut  out  WIDTH  current shift register contents.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse when a word completes.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE or DONE with start=1:
  - memory <= parallelIn; order <= lsbFirst; count <= 0.
  - serialOut <= parallelIn[WIDTH-1] if MSB-first, else parallelIn[0].
  - Next state SHIFT.
- SHIFT with serialClkposedge=1:
  - MSB-first: memory <= {memory[WIDTH-2:0], serialIn}.
  - LSB-first: memory <= {serialIn, memory[WIDTH-1:1]}.
  - count <= count+1.
- SHIFT with serialClknegedge=1 and serialClkposedge=0: serialOut <= memory[WIDTH-1] if MSB-first, else memory[0]. memory is already post-shift here, so this is the next transmit bit.
- Both strobes high in the same cycle: the sample action is applied and the drive strobe is ignored.
- SHIFT when the sample completes count WIDTH: next state DONE. In DONE, done=1 and busy=0.
- DONE without start: next state IDLE.
- Strobes in IDLE or DONE are ignored: memory and serialOut hold.
- start in SHIFT is ignored.
- abort in SHIFT: next state IDLE, no done pulse. memory and serialOut hold their current values.
- abort has priority over the sample strobe in the same cycle.
- reset overrides everything.
- count width is $clog2(WIDTH+1). It never exceeds WIDTH and never wraps.

## Timing
- Reset values, one cycle after reset is sampled high:
  - serialOut=0, parallelOut=0, busy=0, done=0.
  - count=0, state=IDLE, order=0.
- start accepted at cycle n: busy=1 and the first bit is on serialOut at n+1.
- Sample strobe at cycle k: the updated parallelOut is visible at k+1.
- WIDTH-th sample strobe at cycle k: done=1 and busy=0 at k+1. The received word is stable on parallelOut from k+1 until the next start.
- done is exactly one cycle wide. A start during the DONE cycle begins a back-to-back transfer with no idle gap: busy=1 in the following cycle.
- Reset asserted mid-transfer: all outputs take their reset values at the next cycle, with no done pulse.

## Structure
- Shared include file spiengine_defs.v holds:
  - state encodings SE_IDLE=2'b00, SE_SHIFT=2'b01, SE_DONE=2'b10;
  - bit-order constants MSB_FIRST=0, LSB_FIRST=1.
- One sub-module, bitcounter:
  - parameter MAX;
  - inputs clk, reset, clear, inc;
  - output terminal, registered, high when count reaches MAX.
- The FSM, shift register and serialOut register live in spi_shift_engine.

## Test plan
- MSB-first, WIDTH=8: parallelIn=0xC4, serialIn bits 1,0,0,0,0,0,0,0 on successive sample strobes, with drive strobes interleaved. Expected: serialOut sequence 1,1,0,0,0,1,0,0; parallelOut=0x80; done for one cycle after the 8th sample; busy low in that same cycle.
- LSB-first, same stimulus: serialOut sequence 0,0,1,0,0,0,1,1; parallelOut=0x01.
- Reset or abort after 3 sample strobes: reset gives all outputs at reset values next cycle; abort gives state IDLE with busy=0, no done ever, and parallelOut equal to the 3-bit-shifted value.
- start pulsed mid-transfer: ignored, with no reload and the transfer completing normally. A start in the DONE cycle begins the next word immediately with busy=1 the following cycle.
- Both strobes asserted on one cycle: exactly one shift occurs, serialOut is unchanged, and count increments by 1.
- WIDTH=16 sweep of 100 random words in both orders: parallelOut equals the serialIn bit sequence in the selected order, and serialOut equals parallelIn in the selected order.
